// File: rtl/icache_direct_pkg.sv
// Shared LC-3b cache types: line/offset widths, index/tag widths, FSM state.
// Used by icache_direct and icache_control.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cache_line;
    typedef logic [3:0]   lc3b_c_offset;

    localparam int DEF_NUM_SETS = 8;
    localparam int C_INDEX_W    = $clog2(DEF_NUM_SETS);
    localparam int C_TAG_W      = 12 - C_INDEX_W;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } icache_state_t;

    function automatic lc3b_word line_word(
        input lc3b_cache_line line,
        input logic [2:0]     sel
    );
        return line[{sel, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side request bus and physical-memory line bus of the icache.
// slave: the cache; master: fetch stage plus memory.
interface icache_direct_if;

    logic [15:0]  icache_address;
    logic         icache_read;
    logic [15:0]  icache_rdata;
    logic         icache_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output icache_address, icache_read, pmem_rdata, pmem_resp,
        input  icache_rdata, icache_resp, pmem_address, pmem_read
    );

    modport slave (
        input  icache_address, icache_read, pmem_rdata, pmem_resp,
        output icache_rdata, icache_resp, pmem_address, pmem_read
    );

endinterface

// File: rtl/icache_direct_control.sv
// IDLE/FILL controller: latches the miss line address, drives pmem_read
// and produces the line-load strobe and the response gate.
import lc3b_types::*;

module icache_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        hit,
    input  logic [11:0] line_addr,
    input  logic        pmem_resp,
    output logic        pmem_read,
    output logic [15:0] miss_addr,
    output logic        load_line,
    output logic        resp_gate,
    output logic        miss_start
);

    icache_state_t state;

    assign miss_start = (state == S_IDLE) && read && !hit;
    assign load_line  = (state == S_FILL) && pmem_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pmem_read <= 1'b0;
            miss_addr <= '0;
            resp_gate <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (read && !hit) begin
                        state     <= S_FILL;
                        pmem_read <= 1'b1;
                        miss_addr <= {line_addr, 4'b0000};
                        resp_gate <= 1'b0;
                    end
                end
                S_FILL: begin
                    // The fill always completes for miss_addr; no abort.
                    if (pmem_resp) begin
                        state     <= S_IDLE;
                        pmem_read <= 1'b0;
                        miss_addr <= '0;
                        resp_gate <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with same-cycle hit response.
// Optional macro ICACHE_STATS_EN adds saturating hit/miss counters.
import lc3b_types::*;

module icache_direct #(
    parameter int NUM_SETS = DEF_NUM_SETS
) (
    input  logic              clk,
    input  logic              rst,
`ifdef ICACHE_STATS_EN
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count,
`endif
    icache_direct_if.slave    bus
);

    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = 12 - IW;

    logic [IW-1:0]       idx;
    logic [TW-1:0]       tag;
    logic [IW-1:0]       fill_idx;
    logic [TW-1:0]       fill_tag;
    logic [15:0]         miss_addr;
    logic                hit;
    logic                pmem_read;
    logic                load_line;
    logic                resp_gate;
    logic                miss_start;
    logic                unused_bits;

    logic [NUM_SETS-1:0] valid;
    logic [TW-1:0]       tags  [NUM_SETS];
    lc3b_cache_line      lines [NUM_SETS];

    assign idx      = bus.icache_address[4 +: IW];
    assign tag      = bus.icache_address[15 -: TW];
    assign fill_idx = miss_addr[4 +: IW];
    assign fill_tag = miss_addr[15 -: TW];

    assign unused_bits = ^{bus.icache_address[0], miss_addr[3:0]};

    assign hit = bus.icache_read && valid[idx] && (tags[idx] == tag);

    assign bus.icache_resp  = hit && resp_gate;
    assign bus.icache_rdata = line_word(lines[idx], bus.icache_address[3:1]);
    assign bus.pmem_read    = pmem_read;
    assign bus.pmem_address = miss_addr;

    icache_control u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .read       (bus.icache_read),
        .hit        (hit),
        .line_addr  (bus.icache_address[15:4]),
        .pmem_resp  (bus.pmem_resp),
        .pmem_read  (pmem_read),
        .miss_addr  (miss_addr),
        .load_line  (load_line),
        .resp_gate  (resp_gate),
        .miss_start (miss_start)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (load_line) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    // Tags and data carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (load_line) begin
            tags[fill_idx]  <= fill_tag;
            lines[fill_idx] <= bus.pmem_rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (bus.icache_resp && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_start && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: directed scenarios then random traffic
// checked against a set/line-level reference model.
module tb_icache_direct;

    localparam int NUM_SETS = 8;

    typedef struct {
        bit          chk;
        bit          resp;
        logic [15:0] rdata;
        bit          pread;
        logic [15:0] paddr;
        logic [15:0] hc;
        logic [15:0] mc;
    } exp_t;

    logic clk;
    logic rst;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    icache_direct_if bus ();

    icache_direct #(.NUM_SETS(NUM_SETS)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ICACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: which line address each set currently holds.
    bit          m_valid [NUM_SETS];
    logic [11:0] m_la    [NUM_SETS];
    bit          m_busy  = 0;
    bit          m_known = 0;
    logic [11:0] m_miss  = '0;
    logic [15:0] m_hc    = '0;
    logic [15:0] m_mc    = '0;
    int          wcnt    = 0;
    int          lat     = 3;

    function automatic logic [15:0] mem_word(input logic [11:0] la,
                                             input logic [2:0] k);
        return {la ^ 12'hA5C, k, 1'b1};
    endfunction

    function automatic logic [127:0] mem_line(input logic [11:0] la);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[k*16 +: 16] = mem_word(la, 3'(k));
        return l;
    endfunction

    task automatic cyc(input bit r, input logic [15:0] a,
                       input bit rd, input bit spur);
        bit          presp;
        bit          mhit;
        int          s;
        logic [11:0] la;
        exp_t        e;
        @(posedge clk);
        #1;
        la = a[15:4];
        s  = int'(la) % NUM_SETS;
        if (m_busy) begin
            wcnt++;
            presp = (wcnt >= lat);
        end else begin
            presp = spur;
        end
        rst                = r;
        bus.icache_address = a;
        bus.icache_read    = rd;
        bus.pmem_resp      = presp;
        if (m_busy && presp) bus.pmem_rdata = mem_line(m_miss);
        else bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        mhit = !m_busy && rd && m_valid[s] && (m_la[s] == la);
        e.chk   = m_known;
        e.resp  = mhit;
        e.rdata = mem_word(la, a[3:1]);
        e.pread = m_busy;
        e.paddr = m_busy ? {m_miss, 4'h0} : 16'h0;
        e.hc    = m_hc;
        e.mc    = m_mc;
        exp_q.push_back(e);
        if (r) begin
            for (int i = 0; i < NUM_SETS; i++) m_valid[i] = 0;
            m_busy  = 0;
            m_known = 1;
            m_hc    = '0;
            m_mc    = '0;
        end else if (m_busy) begin
            if (presp) begin
                m_valid[int'(m_miss) % NUM_SETS] = 1;
                m_la[int'(m_miss) % NUM_SETS]    = m_miss;
                m_busy = 0;
            end
        end else begin
            if (mhit && m_hc != 16'hFFFF) m_hc++;
            if (rd && !mhit) begin
                m_busy = 1;
                m_miss = la;
                wcnt   = 0;
                if (m_mc != 16'hFFFF) m_mc++;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                checks++;
                if (bus.icache_resp !== e.resp) begin
                    errors++;
                    $display("FAIL resp t=%0t got=%b exp=%b", $time,
                             bus.icache_resp, e.resp);
                end
                if (e.resp) begin
                    checks++;
                    if (bus.icache_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL rdata t=%0t addr=%h got=%h exp=%h",
                                 $time, bus.icache_address,
                                 bus.icache_rdata, e.rdata);
                    end
                end
                checks++;
                if (bus.pmem_read !== e.pread) begin
                    errors++;
                    $display("FAIL pmem_read t=%0t got=%b exp=%b", $time,
                             bus.pmem_read, e.pread);
                end
                checks++;
                if (bus.pmem_address !== e.paddr) begin
                    errors++;
                    $display("FAIL pmem_address t=%0t got=%h exp=%h", $time,
                             bus.pmem_address, e.paddr);
                end
`ifdef ICACHE_STATS_EN
                checks++;
                if (hit_count !== e.hc || miss_count !== e.mc) begin
                    errors++;
                    $display("FAIL stats t=%0t hits=%0d/%0d misses=%0d/%0d",
                             $time, hit_count, e.hc, miss_count, e.mc);
                end
`endif
            end
        end
    end

    initial begin
        logic [15:0] a;
        rst                = 1'b1;
        bus.icache_address = '0;
        bus.icache_read    = 1'b0;
        bus.pmem_resp      = 1'b0;
        bus.pmem_rdata     = '0;

        cyc(1, 16'h0000, 0, 0);
        cyc(1, 16'h0000, 1, 1);
        cyc(0, 16'h0000, 0, 0);

        // Cold miss with latency 3, then hit on word 3.
        lat = 3;
        repeat (6) cyc(0, 16'h3006, 1, 0);
        // Resident sweep: every word hits.
        for (int i = 0; i < 8; i++) cyc(0, 16'h3000 + 16'(2 * i), 1, 0);

        // Conflict on set 0 evicts and refills.
        repeat (6) cyc(0, 16'h3080, 1, 0);
        repeat (6) cyc(0, 16'h3000, 1, 0);

        // Address change during fill.
        cyc(1, 16'h0000, 0, 0);
        cyc(0, 16'h3000, 1, 0);
        repeat (12) cyc(0, 16'h4010, 1, 0);
        repeat (2) cyc(0, 16'h3000, 1, 0);

        // Reset in 2nd FILL cycle, then a stray pmem_resp.
        cyc(1, 16'h0000, 0, 0);
        cyc(0, 16'h3000, 1, 0);
        cyc(0, 16'h3000, 1, 0);
        cyc(1, 16'h3000, 1, 0);
        cyc(0, 16'h3000, 0, 1);
        repeat (6) cyc(0, 16'h3000, 1, 0);

        // One miss then seven hits.
        cyc(1, 16'h0000, 0, 0);
        lat = 2;
        repeat (4) cyc(0, 16'h5000, 1, 0);
        for (int i = 1; i < 7; i++) cyc(0, 16'h5000 + 16'(2 * i), 1, 0);
        cyc(0, 16'h5000, 0, 0);

        a = 16'h3000;
        for (int n = 0; n < 3000; n++) begin
            if (!m_busy) lat = $urandom_range(1, 5);
            if ($urandom_range(0, 9) < 3) begin
                a = {8'h30 + 8'($urandom_range(0, 2)), 8'($urandom)};
            end
            cyc(($urandom_range(0, 199) == 0), a,
                ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
